mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that sits on the CPU data-memory bus as a responder, alongside the data RAM. CPU stores to its address window push bytes into a TX FIFO and program the baud divisor. CPU loads return status. A serializer drains the FIFO onto a single `tx` line as 8N1 frames (8E1 when parity is compiled in).

---
 rtl/mmio_uart_tx_pkg.sv | 29 ++
 rtl/mmio_uart_tx_sync_fifo.sv | 56 +++++
 rtl/mmio_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Register map, STATUS bit positions, serializer states and divisor helper shared by mmio_uart_tx.
package mmio_uart_tx_pkg;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int STS_BUSY       = 0;
    localparam int STS_FULL       = 1;
    localparam int STS_EMPTY      = 2;
    localparam int STS_LVL_LSB    = 3;
    localparam int STS_OVERRUN    = 7;
    localparam int STS_PARITY_CAP = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

    // A programmed divisor of zero would never tick; run it as one cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Generic synchronous FIFO: combinational head, push ignored when full, pop ignored when empty.
// Level and flags update on the edge of the push/pop; synchronous active-low reset discards contents.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             pop_data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH):0]       level_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (cnt_q == LW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign level_o    = cnt_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + LW'(1);
                2'b01:   cnt_q <= cnt_q - LW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: 16-byte register window, TX FIFO, 8N1 serializer (8E1 with MMIO_UART_PARITY_EN).
// Zero-latency reads; a full FIFO drops the store and sets sticky OVERRUN (no stall to the CPU).
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_wr_sig,
    input  logic [31:0] mem_wr_data,
    output logic [31:0] mem_rd_data,
    output logic        hit,
    output logic        tx,
    output logic        tx_idle_irq
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    tx_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] divl_q, divl_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        par_q, par_d;
    logic        tx_q, tx_d;
    logic        irq_q, irq_d;
    logic        ovr_q;
    logic [15:0] div_q;
    logic        en_q;

    logic             wr_en;
    logic [1:0]       reg_sel;
    logic             load;
    logic             tick;
    logic             start_ok;
    logic [7:0]       fifo_dat;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_lvl;
    logic [31:0]      status;
    logic             unused_bits;

    assign hit         = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign wr_en       = mem_wr_sig && hit;
    assign reg_sel     = mem_addr[3:2];
    assign tick        = (cnt_q == 16'd0);
    assign start_ok    = en_q && !fifo_empty;
    assign tx          = tx_q;
    assign tx_idle_irq = irq_q;
    assign unused_bits = ^{mem_addr[1:0], mem_wr_data[31:16]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (wr_en && (reg_sel == REG_TXDATA)),
        .push_data_i (mem_wr_data[7:0]),
        .pop_i       (load),
        .pop_data_o  (fifo_dat),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_lvl)
    );

    always_comb begin
        status                       = '0;
        status[STS_BUSY]             = (state_q != S_IDLE);
        status[STS_FULL]             = fifo_full;
        status[STS_EMPTY]            = fifo_empty;
        status[STS_LVL_LSB +: 4]     = 4'(fifo_lvl);
        status[STS_OVERRUN]          = ovr_q;
`ifdef MMIO_UART_PARITY_EN
        status[STS_PARITY_CAP]       = 1'b1;
`endif
        mem_rd_data = '0;
        if (hit) begin
            case (reg_sel)
                REG_STATUS:  mem_rd_data = status;
                REG_DIVISOR: mem_rd_data = {16'd0, div_q};
                REG_CTRL:    mem_rd_data = {31'd0, en_q};
                default:     mem_rd_data = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        divl_d  = divl_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        par_d   = par_q;
        load    = 1'b0;
        if (state_q != S_IDLE) begin
            cnt_d = tick ? (divl_q - 16'd1) : (cnt_q - 16'd1);
        end
        case (state_q)
            S_IDLE:  load = start_ok;
            S_START: if (tick) begin
                state_d = S_DATA;
                bit_d   = '0;
            end
            S_DATA: if (tick) begin
                if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                    state_d = S_PARITY;
`else
                    state_d = S_STOP;
`endif
                end else begin
                    bit_d = bit_q + 3'd1;
                    sh_d  = {1'b0, sh_q[7:1]};
                end
            end
            S_PARITY: if (tick) state_d = S_STOP;
            // Chaining straight into START keeps back-to-back frames gapless.
            S_STOP: if (tick) begin
                if (start_ok) load = 1'b1;
                else          state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            state_d = S_START;
            sh_d    = fifo_dat;
            par_d   = ^fifo_dat;
            divl_d  = eff_div(div_q);
            cnt_d   = divl_d - 16'd1;
        end
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sh_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        irq_d = (state_d == S_IDLE) && fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            divl_q  <= 16'd1;
            bit_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
            ovr_q   <= 1'b0;
            div_q   <= DIV_RESET;
            en_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            divl_q  <= divl_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
            if (wr_en && (reg_sel == REG_DIVISOR)) div_q <= mem_wr_data[15:0];
            if (wr_en && (reg_sel == REG_CTRL))    en_q  <= mem_wr_data[0];
            if (wr_en && (reg_sel == REG_TXDATA) && fifo_full) begin
                ovr_q <= 1'b1;
            end else if (wr_en && (reg_sel == REG_STATUS) && mem_wr_data[STS_OVERRUN]) begin
                ovr_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: stores queue expected frames, a tx-line monitor pops and compares them.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef MMIO_UART_PARITY_EN
    localparam int          NB   = 11;
    localparam logic [31:0] CAP  = 32'h100;
`else
    localparam int          NB   = 10;
    localparam logic [31:0] CAP  = 32'h0;
`endif

    typedef struct {
        logic [7:0] dat;
        int         div;
    } sb_t;

    logic        clk;
    logic        reset_n;
    logic [31:0] mem_addr;
    logic        mem_wr_sig;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;
    logic        hit;
    logic        tx;
    logic        tx_idle_irq;

    sb_t  sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_start = 0;
    int   last_gap = 0;
    bit   mon_busy = 1'b0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_addr    (mem_addr),
        .mem_wr_sig  (mem_wr_sig),
        .mem_wr_data (mem_wr_data),
        .mem_rd_data (mem_rd_data),
        .hit         (hit),
        .tx          (tx),
        .tx_idle_irq (tx_idle_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] exp_frame(input logic [7:0] d);
`ifdef MMIO_UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    task automatic store(input logic [3:0] off, input logic [31:0] d);
        @(negedge clk);
        mem_addr    = BASE | 32'(off);
        mem_wr_data = d;
        mem_wr_sig  = 1'b1;
        @(posedge clk);
        #1 mem_wr_sig = 1'b0;
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        mem_addr = BASE | 32'(off);
        #1 d = mem_rd_data;
    endtask

    task automatic send(input logic [7:0] b, input int div);
        sb_t e;
        e.dat = b;
        e.div = div;
        sb_q.push_back(e);
        store(4'h0, {24'd0, b});
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        bit done;
        done = 1'b0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1 n++;
            done = (sb_q.size() == 0) && !mon_busy && (tx_idle_irq === 1'b1);
        end
        chk("idle_reached", {31'd0, done}, 32'd1);
    endtask

    // Counts edges from just after a store until tx_idle_irq is seen high again.
    task automatic irq_rise_count(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (tx_idle_irq !== 1'b1 && n < 400);
    endtask

    initial begin : monitor
        sb_t         e;
        logic [10:0] want;
        logic [10:0] got;
        int          bad;
        bit          aborted;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1 && tx === 1'b0) begin
                mon_busy   = 1'b1;
                last_gap   = cyc - last_start;
                last_start = cyc;
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                    e.dat = 8'h00;
                    e.div = 1;
                end else begin
                    e = sb_q.pop_front();
                end
                want    = exp_frame(e.dat);
                got     = '0;
                bad     = 0;
                aborted = 1'b0;
                for (int i = 0; i < NB * e.div; i++) begin
                    if (i > 0) @(negedge clk);
                    if (reset_n !== 1'b1) aborted = 1'b1;
                    if (tx !== want[i / e.div]) bad++;
                    if (i % e.div == e.div / 2) got[i / e.div] = tx;
                end
                if (!aborted) begin
                    chk($sformatf("frame_%02h", e.dat), 32'(got), 32'(want));
                    chk($sformatf("bit_timing_%02h", e.dat), 32'(bad), 32'd0);
                end
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] d;
        int          n;
        reset_n     = 1'b0;
        mem_addr    = '0;
        mem_wr_sig  = 1'b0;
        mem_wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_irq", {31'd0, tx_idle_irq}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        rd(4'h4, d); chk("rst_status", d, 32'h04 | CAP);
        rd(4'h8, d); chk("rst_divisor", d, 32'd4);
        rd(4'hC, d); chk("rst_ctrl", d, 32'd1);
        rd(4'h0, d); chk("txdata_reads_zero", d, 32'd0);
        mem_addr = 32'h0000_2004;
        #1;
        chk("miss_hit", {31'd0, hit}, 32'd0);
        chk("miss_rdata", mem_rd_data, 32'd0);
        mem_addr = 32'h0000_100F;
        #1 chk("window_top_hit", {31'd0, hit}, 32'd1);

        // Single 0x55 frame with cycle-exact start and idle-irq timing.
        send(8'h55, 4);
        rd(4'h4, d); chk("status_at_store_edge", d, 32'h08 | CAP);
        chk("irq_at_store_edge", {31'd0, tx_idle_irq}, 32'd1);
        @(posedge clk);
        #1;
        chk("tx_falls_next_edge", {31'd0, tx}, 32'd0);
        chk("irq_low_next_edge", {31'd0, tx_idle_irq}, 32'd0);
        rd(4'h4, d); chk("status_busy", d, 32'h05 | CAP);
        irq_rise_count(n);
        chk("irq_rise_0x55", 32'(n + 1), 32'(1 + NB * 4));
        wait_idle(100);

        // Back-to-back frames: no idle gap, one byte left queued during frame 1.
        send(8'hA5, 4);
        send(8'h3C, 4);
        repeat (10) @(posedge clk);
        #1;
        rd(4'h4, d); chk("level_mid_frame", d, 32'h09 | CAP);
        wait_idle(300);
        chk("b2b_gap", 32'(last_gap), 32'(NB * 4));

        // Disabled transmitter: fill past full, then clear overrun and drain.
        store(4'hC, 32'd0);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) send(8'(8'h10 + i), 4);
            else       store(4'h0, 32'(8'h10 + i));
        end
        rd(4'h4, d); chk("full_overrun", d, 32'hC2 | CAP);
        store(4'h4, 32'h80);
        rd(4'h4, d); chk("overrun_cleared", d, 32'h42 | CAP);
        store(4'hC, 32'd1);
        wait_idle(8 * NB * 4 + 200);

        // Divisor change mid-frame applies only to the next frame; divisor 0 runs as 1.
        send(8'h96, 4);
        repeat (10) @(posedge clk);
        store(4'h8, 32'hFFFF_0002);
        rd(4'h8, d); chk("divisor_upper_zero", d, 32'd2);
        send(8'h3C, 2);
        wait_idle(300);
        store(4'h8, 32'd0);
        send(8'h5A, 1);
        wait_idle(100);
        rd(4'h8, d); chk("divisor_zero_reads", d, 32'd0);

        // Reset in DATA bit 3 with a second byte still queued.
        store(4'h8, 32'd4);
        send(8'hF0, 4);
        store(4'h0, 32'h11);
        repeat (17) @(posedge clk);
        #1 chk("bit3_of_f0", {31'd0, tx}, 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midframe_rst_tx", {31'd0, tx}, 32'd1);
        chk("midframe_rst_irq", {31'd0, tx_idle_irq}, 32'd1);
        rd(4'h4, d); chk("midframe_rst_status", d, 32'h04 | CAP);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (60) @(posedge clk);
        #1 chk("tx_idle_after_rst", {31'd0, tx}, 32'd1);
        wait_idle(50);

        // Frame length (10 or 11 bits) measured via idle-irq, parity bit set for 0x07.
        send(8'h07, 4);
        irq_rise_count(n);
        chk("irq_rise_0x07", 32'(n), 32'(1 + NB * 4));
        wait_idle(100);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
